tls_ped_ctrl: RTL and testbench
===============================

# tls_ped_ctrl

Pedestrian crossing controller downstream of the two-road traffic light sequencer. It consumes the one-hot lamp codes for road A and road B and debounces one push-button per crossing. A walk phase is granted only at the onset of the crossed road's red. The block also supervises the lamp codes and latches a sticky fault on any illegal or unsafe combination.

## Interface
- `WALK_CYC`, default 6: cycles of steady WALK per grant.
- `FLASH_CYC`, default 4: cycles of flashing DON'T-WALK after WALK.
- `DEB_CYC`, default 3: consecutive high samples needed to register a button press.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `la` in 3: road A lamp code. G=100, Y=010, R=001.
- `lb` in 3: road B lamp code, same encoding.
- `req_a` in 1: raw button, crossing over road A, active-high.
- `req_b` in 1: raw button, crossing over road B, active-high.
- `walk_a`, `walk_b` out 1: steady WALK lamp.
- `dontwalk_a`, `dontwalk_b` out 1: DON'T-WALK lamp; flashes in FLASH.
- `cnt_a`, `cnt_b` out 4: flash countdown; 0 outside FLASH.
- `fault` out 1: sticky supervision fault.

## Operation
- Crossing A is safe only while `la`=001; crossing B only while `lb`=001. The two crossings are independent, identical FSMs.
- Debounce: per-button counter of consecutive high samples, saturating at DEB_CYC. It clears on any low sample. Reaching DEB_CYC produces one press pulse; the button must go low before it can pulse again.
- Red onset for A: `la`=001 this sample and `la_q`≠001, where `la_q` is the previous sample. `la_q` resets to 001, so no onset occurs right after reset.
- FSM states and transitions:
  - IDLE → ARMED on a press pulse.
  - ARMED → WALK on red onset. A press mid-red waits for the next onset.
  - WALK lasts WALK_CYC cycles, then → FLASH.
  - FLASH lasts FLASH_CYC cycles, then → ARMED if `pending` is set, else → IDLE.
- Presses during WALK are ignored. Presses during FLASH set `pending`, which clears on leaving FLASH.
- Outputs by state:
  - IDLE/ARMED: walk=0, dontwalk=1, cnt=0.
  - WALK: walk=1, dontwalk=0, cnt=0.
  - FLASH: walk=0. dontwalk is 1 on the first FLASH cycle, then toggles every cycle. cnt runs FLASH_CYC down to 1, one step per cycle.
- Fault conditions, checked every cycle:
  - `la` or `lb` not in {100, 010, 001}.
  - `la` and `lb` both ≠001.
  - `la`≠001 while A is in WALK/FLASH, or `lb`≠001 while B is in WALK/FLASH (conflict).
- On fault:
  - `fault`=1 until reset.
  - Both FSMs forced to IDLE; pending and debounce counters cleared.
  - All presses ignored.
  - walk=0, dontwalk=1 steady, cnt=0.
- Width rule: phase counter is $clog2(max(WALK_CYC, FLASH_CYC)+1) bits. FLASH_CYC ≤ 15 so cnt fits 4 bits.

## Timing
- Reset (`rst`=0 at a clk edge):
  - All FSMs IDLE; counters and pending cleared; `la_q`=`lb_q`=001.
  - Outputs: walk 0, dontwalk 1, cnt 0, fault 0.
  - Reset mid-WALK/FLASH takes effect at that same edge.
- All outputs are registered.
- walk rises on the edge after the first `la`=001 sample (1-cycle latency from onset).
- A press pulse is registered on the edge of the DEB_CYC-th consecutive high sample.
- `fault` rises on the edge after the offending sample. walk drops on that same edge.
- If a red onset and a press pulse occur in the same cycle in IDLE, the FSM goes to ARMED only; WALK waits for the next onset.
- If a fault and a state transition occur in the same cycle, the fault wins.

## Structure
- Shared package `tls_pkg` holds:
  - lamp code constants LAMP_G=3'b100, LAMP_Y=3'b010, LAMP_R=3'b001;
  - the pedestrian state enum {IDLE, ARMED, WALK, FLASH}.
  - The sequencer reuses the lamp constants.
- Sub-module `tls_ped_xing`: debouncer, FSM, phase counter and outputs for one crossing, instantiated twice.
- The top holds input sample registers, the onset detect and the fault supervisor. It broadcasts `fault` to both instances.

## Test plan
All scenarios use WALK_CYC=6, FLASH_CYC=4, DEB_CYC=3.
- Reset with `la`=001, `lb`=100, `req_a` high throughout → walk_a=0, dontwalk_a=1, fault=0; no WALK during the current red.
- `req_a` high 3 cycles while `la`=100, then `la` 010→001 → walk_a=1 one cycle after 001 for 6 cycles. Then FLASH for 4 cycles: cnt_a 4,3,2,1, dontwalk_a 1,0,1,0. Then IDLE.
- `req_a` high 2 cycles then low → no press; next red onset produces no WALK.
- `req_a` pressed during FLASH → FSM returns to ARMED; WALK at the following onset, not the current red.
- `la`→100 during walk_a=1 → next edge: walk_a=0, fault=1. Later presses are ignored until `rst`=0.
- `la`=110 → fault=1 next cycle. After reset, `la`=100 with `lb`=100 → fault=1 next cycle.

Source files
------------

// File: rtl/tls_pkg.sv
// Shared lamp encodings and pedestrian-phase state for the traffic light slice.
package tls_pkg;

  localparam logic [2:0] LAMP_G = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b001;

  typedef enum logic [1:0] {IDLE, ARMED, WALK, FLASH} ped_state_t;

  function automatic logic lamp_legal(input logic [2:0] code);
    return (code == LAMP_G) || (code == LAMP_Y) || (code == LAMP_R);
  endfunction

endpackage

// File: rtl/tls_ped_xing.sv
// One pedestrian crossing: button debounce, walk/flash phase FSM and lamp outputs.
module tls_ped_xing
  import tls_pkg::*;
#(
  parameter int WALK_CYC  = 6,
  parameter int FLASH_CYC = 4,
  parameter int DEB_CYC   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       onset,
  input  logic       fault,
  output logic       active,
  output logic       walk,
  output logic       dontwalk,
  output logic [3:0] cnt
);

  localparam int PH_MAX = (WALK_CYC > FLASH_CYC) ? WALK_CYC : FLASH_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int DEB_W  = $clog2(DEB_CYC + 1);

  ped_state_t       state, state_n;
  logic [PH_W-1:0]  ph, ph_n;
  logic [DEB_W-1:0] deb, deb_n;
  logic             pending, pending_n;
  logic             press;
  logic             walk_n, dontwalk_n;
  logic [3:0]       cnt_n;

  assign active = (state == WALK) || (state == FLASH);

  // Press fires once, on the DEB_CYC-th consecutive high sample; the count then
  // sits saturated until the button is released.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    press = 1'b0;
    deb_n = '0;
    if (!fault && req) begin
      press = (deb == DEB_W'(DEB_CYC - 1));
      deb_n = (deb == DEB_W'(DEB_CYC)) ? deb : deb + 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    ph_n      = ph;
    pending_n = pending;
    if (fault) begin
      state_n   = IDLE;
      ph_n      = '0;
      pending_n = 1'b0;
    end else begin
      case (state)
        IDLE:  if (press) state_n = ARMED;
        ARMED: if (onset) begin
          state_n = WALK;
          ph_n    = PH_W'(WALK_CYC - 1);
        end
        WALK:  if (ph == '0) begin
          state_n = FLASH;
          ph_n    = PH_W'(FLASH_CYC - 1);
        end else begin
          ph_n = ph - 1'b1;
        end
        FLASH: if (ph == '0) begin
          state_n   = (pending || press) ? ARMED : IDLE;
          pending_n = 1'b0;
        end else begin
          ph_n = ph - 1'b1;
          if (press) pending_n = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they leave the flops already aligned.
  always_comb begin
    walk_n     = (state_n == WALK);
    dontwalk_n = (state_n != WALK);
    cnt_n      = '0;
    if (state_n == FLASH) begin
      dontwalk_n = (state == FLASH) ? ~dontwalk : 1'b1;
      cnt_n      = 4'(ph_n) + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ph       <= '0;
      deb      <= '0;
      pending  <= 1'b0;
      walk     <= 1'b0;
      dontwalk <= 1'b1;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      ph       <= ph_n;
      deb      <= deb_n;
      pending  <= pending_n;
      walk     <= walk_n;
      dontwalk <= dontwalk_n;
      cnt      <= cnt_n;
    end
  end

endmodule

// File: rtl/tls_ped_ctrl.sv
// Two-crossing pedestrian controller: red-onset detection and lamp-code supervision.
module tls_ped_ctrl
  import tls_pkg::*;
#(
  parameter int WALK_CYC  = 6,
  parameter int FLASH_CYC = 4,
  parameter int DEB_CYC   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] la,
  input  logic [2:0] lb,
  input  logic       req_a,
  input  logic       req_b,
  output logic       walk_a,
  output logic       walk_b,
  output logic       dontwalk_a,
  output logic       dontwalk_b,
  output logic [3:0] cnt_a,
  output logic [3:0] cnt_b,
  output logic       fault
);

  logic [2:0] la_q, lb_q;
  logic       onset_a, onset_b;
  logic       active_a, active_b;
  logic       violation, fault_now;

  assign onset_a = (la == LAMP_R) && (la_q != LAMP_R);
  assign onset_b = (lb == LAMP_R) && (lb_q != LAMP_R);

  // A crossing in WALK/FLASH needs its road held at red the whole time.
  assign violation = !lamp_legal(la) || !lamp_legal(lb)
                  || ((la != LAMP_R) && (lb != LAMP_R))
                  || (active_a && (la != LAMP_R))
                  || (active_b && (lb != LAMP_R));
  assign fault_now = fault || violation;

  // Sample history resets to red so reset itself never looks like an onset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      la_q  <= LAMP_R;
      lb_q  <= LAMP_R;
      fault <= 1'b0;
    end else begin
      la_q  <= la;
      lb_q  <= lb;
      fault <= fault_now;
    end
  end

  tls_ped_xing #(.WALK_CYC(WALK_CYC), .FLASH_CYC(FLASH_CYC), .DEB_CYC(DEB_CYC)) u_xing_a (
    .clk      (clk),
    .rst      (rst),
    .req      (req_a),
    .onset    (onset_a),
    .fault    (fault_now),
    .active   (active_a),
    .walk     (walk_a),
    .dontwalk (dontwalk_a),
    .cnt      (cnt_a)
  );

  tls_ped_xing #(.WALK_CYC(WALK_CYC), .FLASH_CYC(FLASH_CYC), .DEB_CYC(DEB_CYC)) u_xing_b (
    .clk      (clk),
    .rst      (rst),
    .req      (req_b),
    .onset    (onset_b),
    .fault    (fault_now),
    .active   (active_b),
    .walk     (walk_b),
    .dontwalk (dontwalk_b),
    .cnt      (cnt_b)
  );

endmodule

// File: tb/tb_tls_ped_ctrl.sv
// Self-checking bench for tls_ped_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_tls_ped_ctrl;

  localparam int WALK  = 6;
  localparam int FLASH = 4;
  localparam int DEB   = 3;
  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b100;

  logic       clk, rst;
  logic [2:0] la, lb;
  logic       req_a, req_b;
  logic       walk_a, walk_b, dontwalk_a, dontwalk_b, fault;
  logic [3:0] cnt_a, cnt_b;

  int n_checks = 0;
  int n_pass   = 0;

  tls_ped_ctrl #(.WALK_CYC(WALK), .FLASH_CYC(FLASH), .DEB_CYC(DEB)) dut (
    .clk        (clk),
    .rst        (rst),
    .la         (la),
    .lb         (lb),
    .req_a      (req_a),
    .req_b      (req_b),
    .walk_a     (walk_a),
    .walk_b     (walk_b),
    .dontwalk_a (dontwalk_a),
    .dontwalk_b (dontwalk_b),
    .cnt_a      (cnt_a),
    .cnt_b      (cnt_b),
    .fault      (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: remaining walk/flash cycles per crossing, an armed flag,
  // a pending flag and a consecutive-high counter for each button.
  int         m_deb[2], m_walk[2], m_flash[2];
  bit         m_armed[2], m_pend[2], m_fault;
  logic [2:0] m_prev[2];

  function automatic bit legal(input logic [2:0] c);
    return (c == R) || (c == Y) || (c == G);
  endfunction

  function automatic logic exp_dw(input int i);
    if (m_flash[i] > 0) return ((FLASH - m_flash[i]) % 2) == 0;
    return m_walk[i] == 0;
  endfunction

  task automatic model_step();
    logic [2:0] lamp[2];
    logic       rq[2];
    bit         viol, ff, press, onset;
    lamp[0] = la; lamp[1] = lb; rq[0] = req_a; rq[1] = req_b;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_deb[i] = 0; m_walk[i] = 0; m_flash[i] = 0;
        m_armed[i] = 0; m_pend[i] = 0; m_prev[i] = R;
      end
      m_fault = 0;
    end else begin
      viol = !legal(la) || !legal(lb) || (la != R && lb != R);
      for (int i = 0; i < 2; i++)
        if (lamp[i] != R && (m_walk[i] > 0 || m_flash[i] > 0)) viol = 1;
      ff = m_fault || viol;
      for (int i = 0; i < 2; i++) begin
        press     = !ff && rq[i] && (m_deb[i] == DEB - 1);
        m_deb[i]  = (ff || !rq[i]) ? 0 : ((m_deb[i] < DEB) ? m_deb[i] + 1 : DEB);
        onset     = (lamp[i] == R) && (m_prev[i] != R);
        m_prev[i] = lamp[i];
        if (ff) begin
          m_walk[i] = 0; m_flash[i] = 0; m_armed[i] = 0; m_pend[i] = 0;
        end else if (m_walk[i] > 0) begin
          m_walk[i]--;
          if (m_walk[i] == 0) m_flash[i] = FLASH;
        end else if (m_flash[i] > 0) begin
          if (press) m_pend[i] = 1;
          m_flash[i]--;
          if (m_flash[i] == 0) begin
            m_armed[i] = m_pend[i];
            m_pend[i]  = 0;
          end
        end else if (m_armed[i]) begin
          if (onset) begin
            m_walk[i]  = WALK;
            m_armed[i] = 0;
          end
        end else if (press) begin
          m_armed[i] = 1;
        end
      end
      m_fault = ff;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    check("model walk_a", walk_a, m_walk[0] > 0);
    check("model walk_b", walk_b, m_walk[1] > 0);
    check("model dontwalk_a", dontwalk_a, exp_dw(0));
    check("model dontwalk_b", dontwalk_b, exp_dw(1));
    check("model cnt_a", cnt_a, 4'(m_flash[0]));
    check("model cnt_b", cnt_b, 4'(m_flash[1]));
    check("model fault", fault, m_fault);
  end

  task automatic tick(input logic [2:0] a, input logic [2:0] b, input logic ra, input logic rb);
    la = a; lb = b; req_a = ra; req_b = rb;
    @(negedge clk);
  endtask

  logic [5:0] pairs[5];
  logic [5:0] pair;
  logic [2:0] na, nb;
  logic       ra, rb;

  initial begin
    pairs = '{{R, G}, {R, Y}, {R, R}, {G, R}, {Y, R}};

    // Reset while A is already red, button held: armed but no walk this red.
    rst = 1'b0;
    tick(R, G, 1, 0);
    tick(R, G, 1, 0);
    rst = 1'b1;
    repeat (6) tick(R, G, 1, 0);
    check("rst walk_a", walk_a, 0);
    check("rst dontwalk_a", dontwalk_a, 1);
    check("rst cnt_a", cnt_a, 0);
    check("rst fault", fault, 0);

    // Full walk/flash cycle after a debounced press.
    rst = 1'b0;
    tick(G, R, 0, 0);
    rst = 1'b1;
    repeat (3) tick(G, R, 1, 0);
    tick(Y, R, 0, 0);
    tick(R, G, 0, 0);
    check("walk rise", walk_a, 1);
    for (int i = 0; i < 5; i++) begin
      tick(R, G, 0, 0);
      check("walk hold", walk_a, 1);
    end
    for (int i = 0; i < 4; i++) begin
      tick(R, G, 0, 0);
      check("flash walk_a", walk_a, 0);
      check("flash cnt_a", cnt_a, 4'(4 - i));
      check("flash dontwalk_a", dontwalk_a, (i % 2) == 0);
    end
    tick(R, G, 0, 0);
    check("idle cnt_a", cnt_a, 0);
    check("idle dontwalk_a", dontwalk_a, 1);

    // Two high samples only: no press registered.
    tick(G, R, 1, 0);
    tick(G, R, 1, 0);
    tick(G, R, 0, 0);
    tick(Y, R, 0, 0);
    tick(R, G, 0, 0);
    check("short press", walk_a, 0);
    tick(R, G, 0, 0);
    check("short press 2", walk_a, 0);

    // Press during flash re-arms for the following onset.
    repeat (3) tick(G, R, 1, 0);
    tick(Y, R, 0, 0);
    tick(R, G, 0, 0);
    repeat (5) tick(R, G, 0, 0);
    tick(R, G, 0, 0);
    repeat (3) tick(R, G, 1, 0);
    tick(R, G, 0, 0);
    check("rearm walk_a", walk_a, 0);
    check("rearm dontwalk_a", dontwalk_a, 1);
    repeat (2) begin
      tick(R, G, 0, 0);
      check("rearm same red", walk_a, 0);
    end
    tick(G, R, 0, 0);
    tick(Y, R, 0, 0);
    tick(R, G, 0, 0);
    check("rearm next onset", walk_a, 1);

    // Road A turns green mid-walk: conflict fault, then everything frozen.
    tick(G, R, 0, 0);
    check("conflict walk_a", walk_a, 0);
    check("conflict fault", fault, 1);
    check("conflict dontwalk_a", dontwalk_a, 1);
    repeat (4) tick(G, R, 1, 1);
    repeat (4) tick(R, G, 1, 1);
    check("sticky fault", fault, 1);
    check("sticky walk_a", walk_a, 0);

    // Illegal code, then both roads non-red.
    rst = 1'b0;
    tick(R, G, 0, 0);
    rst = 1'b1;
    check("clear fault", fault, 0);
    tick(3'b110, R, 0, 0);
    check("illegal fault", fault, 1);
    rst = 1'b0;
    tick(R, G, 0, 0);
    rst = 1'b1;
    tick(G, G, 0, 0);
    check("both green fault", fault, 1);

    // Randomized traffic against the model.
    na = R; nb = G; ra = 0; rb = 0;
    for (int c = 0; c < 4000; c++) begin
      rst = !(($urandom_range(0, 199) == 0) || (m_fault && $urandom_range(0, 2) == 0));
      if ($urandom_range(0, 7) == 0) begin
        pair = pairs[$urandom_range(0, 4)];
        na = pair[5:3];
        nb = pair[2:0];
      end
      if ($urandom_range(0, 399) == 0) na = 3'($urandom);
      if ($urandom_range(0, 2) == 0) ra = ~ra;
      if ($urandom_range(0, 2) == 0) rb = ~rb;
      tick(na, nb, ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
